// File: rtl/instr_sequencer_if.sv
// Bus between the instruction sequencer and its surroundings (instruction ROM, decoder, operator controls).
interface instr_sequencer_if #(
   parameter int PC_W  = 4,
   parameter int IW    = 12,
   parameter int CNT_W = 8
);
   logic             run;
   logic             step;
   logic [PC_W-1:0]  im_addr;
   logic [IW-1:0]    im_data;
   logic [IW-1:0]    instr;
   logic             exec_en;
   logic [PC_W-1:0]  pc;
   logic             halted;
   logic             illegal;
   logic [CNT_W-1:0] retired;

   // sequencer side
   modport master (
      input  run, step, im_data,
      output im_addr, instr, exec_en, pc, halted, illegal, retired
   );

   // environment side
   modport slave (
      output run, step, im_data,
      input  im_addr, instr, exec_en, pc, halted, illegal, retired
   );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer: FETCH -> DECODE -> EXEC per instruction,
// with free-run, single-step and halt. The retired-instruction counter is
// built only when INSTR_SEQ_COUNT_EN is defined; otherwise retired reads 0.
module instr_sequencer #(
   parameter int PC_W  = 4,
   parameter int IW    = 12,
   parameter int CNT_W = 8
) (
   input logic              clk,
   input logic              reset,
   instr_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      HALT   = 3'd4
   } state_t;

   state_t          state, state_nx;
   logic [PC_W-1:0] pc_q;
   logic [IW-1:0]   instr_q;
   logic            halted_q, illegal_q;

   logic [2:0] opc;
   logic       op_legal, op_halt;
   logic       exec_en_c, pc_adv, set_halt, set_illegal;

   assign opc = instr_q[IW-1 -: 3];

   // opcode classification from the (stable) instruction register
   always_comb begin
      op_legal = 1'b0;
      op_halt  = 1'b0;
      case (opc)
         3'b000, 3'b001, 3'b101, 3'b110: op_legal = 1'b1;
         3'b111:                         op_halt  = 1'b1;
         default:                        ;
      endcase
   end

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // next-state logic; step and run are only looked at in IDLE and EXEC
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.run || bus.step) state_nx = FETCH;
         FETCH:   state_nx = DECODE;
         DECODE:  state_nx = EXEC;
         EXEC:    if (op_halt)      state_nx = HALT;
                  else if (bus.run) state_nx = FETCH;
                  else              state_nx = IDLE;
         HALT:    state_nx = HALT;
         default: state_nx = IDLE;
      endcase
   end

   // outputs decoded from registered state and registered instruction only,
   // so the write strobe cannot glitch
   always_comb begin
      exec_en_c   = 1'b0;
      pc_adv      = 1'b0;
      set_halt    = 1'b0;
      set_illegal = 1'b0;
      if (state == EXEC) begin
         exec_en_c   = op_legal;
         pc_adv      = !op_halt;
         set_halt    = op_halt;
         set_illegal = !op_legal && !op_halt;
      end
   end

   // datapath registers: instruction capture, pc, sticky flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q      <= '0;
         instr_q   <= '0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         if (state == FETCH) instr_q <= bus.im_data;
         if (pc_adv)         pc_q    <= pc_q + 1'b1;
         if (set_halt)       halted_q  <= 1'b1;
         if (set_illegal)    illegal_q <= 1'b1;
      end
   end

`ifdef INSTR_SEQ_COUNT_EN
   logic [CNT_W-1:0] retired_q;

   // saturating count of legal executed instructions
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                    retired_q <= '0;
      else if (exec_en_c && (retired_q != {CNT_W{1'b1}})) retired_q <= retired_q + 1'b1;
   end

   assign bus.retired = retired_q;
`else
   assign bus.retired = {CNT_W{1'b0}};
`endif

   assign bus.im_addr = pc_q;
   assign bus.pc      = pc_q;
   assign bus.instr   = instr_q;
   assign bus.exec_en = exec_en_c;
   assign bus.halted  = halted_q;
   assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: per-opcode vector table driven
// by single-step, plus hand sequences for free-run, halt, wrap and reset.
module tb_instr_sequencer;

`ifdef INSTR_SEQ_COUNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [11:0] rom [16];

   int n_checks = 0;
   int n_fail   = 0;

   instr_sequencer_if #(.PC_W(4), .IW(12), .CNT_W(8)) bus ();

   instr_sequencer #(.PC_W(4), .IW(12), .CNT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   assign bus.im_data = rom[bus.im_addr];

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // exec_en must never be high on two consecutive cycles
   logic prev_en = 1'b0;
   always @(negedge clk) begin
      if (!reset && bus.exec_en === 1'b1) check("exec_en_back_to_back", {31'd0, prev_en}, 32'd0);
      prev_en = reset ? 1'b0 : bus.exec_en;
   end

   task automatic do_reset();
      reset    = 1'b1;
      bus.run  = 1'b0;
      bus.step = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // sample n cycles at negedge; step is a one-cycle pulse so drop it on the first sample
   task automatic run_samples(input int n, output int pulses, output logic [63:0] mask);
      pulses = 0;
      mask   = '0;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         bus.step = 1'b0;
         if (bus.exec_en === 1'b1) begin
            pulses++;
            if (i < 64) mask[i] = 1'b1;
         end
      end
   endtask

   typedef struct {
      logic [11:0] word;
      int          exp_pulses;
      logic [3:0]  exp_pc;
      logic        exp_illegal;
      logic        exp_halted;
   } vec_t;

   vec_t        vecs [8];
   int          p;
   logic [63:0] m;

   initial begin
      bus.run  = 1'b0;
      bus.step = 1'b0;
      foreach (rom[i]) rom[i] = 12'h000;

      vecs[0] = '{12'h012, 1, 4'd1, 1'b0, 1'b0};  // load
      vecs[1] = '{12'h245, 1, 4'd1, 1'b0, 1'b0};  // store
      vecs[2] = '{12'h400, 0, 4'd1, 1'b1, 1'b0};  // 010 illegal
      vecs[3] = '{12'h7FF, 0, 4'd1, 1'b1, 1'b0};  // 011 illegal
      vecs[4] = '{12'h800, 0, 4'd1, 1'b1, 1'b0};  // 100 illegal
      vecs[5] = '{12'hA3C, 1, 4'd1, 1'b0, 1'b0};  // add
      vecs[6] = '{12'hC01, 1, 4'd1, 1'b0, 1'b0};  // sub
      vecs[7] = '{12'hE00, 0, 4'd0, 1'b0, 1'b1};  // halt

      // reset state
      do_reset();
      check("rst_pc", {28'd0, bus.pc}, 32'd0);
      check("rst_im_addr", {28'd0, bus.im_addr}, 32'd0);
      check("rst_instr", {20'd0, bus.instr}, 32'd0);
      check("rst_exec_en", {31'd0, bus.exec_en}, 32'd0);
      check("rst_halted", {31'd0, bus.halted}, 32'd0);
      check("rst_illegal", {31'd0, bus.illegal}, 32'd0);
      check("rst_retired", {24'd0, bus.retired}, 32'd0);

      // single-step each opcode class
      foreach (vecs[k]) begin
         rom[0] = vecs[k].word;
         rom[1] = 12'h000;
         do_reset();
         bus.step = 1'b1;
         run_samples(8, p, m);
         check($sformatf("v%0d_pulses", k), p, vecs[k].exp_pulses);
         check($sformatf("v%0d_mask", k), m[31:0], (vecs[k].exp_pulses != 0) ? 32'h8 : 32'h0);
         check($sformatf("v%0d_pc", k), {28'd0, bus.pc}, {28'd0, vecs[k].exp_pc});
         check($sformatf("v%0d_instr", k), {20'd0, bus.instr}, {20'd0, vecs[k].word});
         check($sformatf("v%0d_illegal", k), {31'd0, bus.illegal}, {31'd0, vecs[k].exp_illegal});
         check($sformatf("v%0d_halted", k), {31'd0, bus.halted}, {31'd0, vecs[k].exp_halted});
         check($sformatf("v%0d_retired", k), {24'd0, bus.retired}, CNT_ON ? vecs[k].exp_pulses : 0);
      end

      // free-run program: load, store, halt
      foreach (rom[i]) rom[i] = 12'h000;
      rom[0] = 12'h012; rom[1] = 12'h245; rom[2] = 12'hE00;
      do_reset();
      bus.run = 1'b1;
      run_samples(12, p, m);
      check("prog_mask", m[31:0], 32'h48);
      check("prog_halted", {31'd0, bus.halted}, 32'd1);
      check("prog_pc", {28'd0, bus.pc}, 32'd2);
      check("prog_retired", {24'd0, bus.retired}, CNT_ON ? 32'd2 : 32'd0);
      // HALT absorbs run and step
      bus.step = 1'b1;
      run_samples(9, p, m);
      check("halt_pulses", p, 0);
      check("halt_pc", {28'd0, bus.pc}, 32'd2);
      check("halt_sticky", {31'd0, bus.halted}, 32'd1);
      bus.run = 1'b0;

      // step, then a second step during DECODE is ignored
      foreach (rom[i]) rom[i] = 12'h012;
      do_reset();
      bus.step = 1'b1;
      @(negedge clk);           // FETCH
      bus.step = 1'b0;
      @(negedge clk);           // DECODE
      bus.step = 1'b1;
      run_samples(10, p, m);
      check("step2_pulses", p, 1);
      check("step2_mask", m[31:0], 32'h2);
      check("step2_pc", {28'd0, bus.pc}, 32'd1);

      // run dropped mid-instruction: current one completes, then idle
      do_reset();
      bus.run = 1'b1;
      @(negedge clk);           // FETCH
      @(negedge clk);           // DECODE
      bus.run = 1'b0;
      run_samples(8, p, m);
      check("rundrop_pulses", p, 1);
      check("rundrop_pc", {28'd0, bus.pc}, 32'd1);

      // 17 adds in free run: pc wraps 15->0 and continues at address 0
      foreach (rom[i]) rom[i] = 12'hA00;
      do_reset();
      bus.run = 1'b1;
      run_samples(48, p, m);
      check("wrap_pulses16", p, 16);
      @(negedge clk);           // sample 49: FETCH at wrapped address
      check("wrap_pc0", {28'd0, bus.pc}, 32'd0);
      check("wrap_im_addr0", {28'd0, bus.im_addr}, 32'd0);
      run_samples(2, p, m);     // samples 50, 51 (EXEC of instruction 17)
      check("wrap_exec17", p, 1);
      bus.run = 1'b0;
      run_samples(4, p, m);
      check("wrap_pc_end", {28'd0, bus.pc}, 32'd1);
      check("wrap_retired", {24'd0, bus.retired}, CNT_ON ? 32'd17 : 32'd0);

      // reset asserted during DECODE
      foreach (rom[i]) rom[i] = 12'h012;
      do_reset();
      bus.step = 1'b1;
      @(negedge clk);           // FETCH
      bus.step = 1'b0;
      @(negedge clk);           // DECODE
      check("rstdec_pre_instr", {20'd0, bus.instr}, 32'h012);
      reset = 1'b1;
      #1;
      check("rstdec_pc", {28'd0, bus.pc}, 32'd0);
      check("rstdec_instr", {20'd0, bus.instr}, 32'd0);
      check("rstdec_exec_en", {31'd0, bus.exec_en}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_samples(6, p, m);
      check("rstdec_no_pulse", p, 0);
      check("rstdec_pc_hold", {28'd0, bus.pc}, 32'd0);
      bus.step = 1'b1;          // idle again: a step runs normally
      run_samples(5, p, m);
      check("rstdec_step_mask", m[31:0], 32'h8);

`ifdef INSTR_SEQ_COUNT_EN
      // 300 legal instructions: counter saturates
      foreach (rom[i]) rom[i] = 12'hA00;
      do_reset();
      bus.run = 1'b1;
      run_samples(900, p, m);
      bus.run = 1'b0;
      run_samples(4, p, m);
      check("sat_retired", {24'd0, bus.retired}, 32'd255);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle control sequencer for the 12-bit datapath:
- fetches instructions from a 16-entry instruction memory into an instruction register;
- holds that register stable while the combinational instruction decoder settles;
- emits a single-cycle execute strobe that gates all register-file and data-memory writes.

It owns the program counter and supports free-run, single-step and halt.

## Interface
Parameters:
- PC_W, 4, program counter / instruction address width
- IW, 12, instruction word width
- CNT_W, 8, retired-instruction counter width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; one clock, asynchronous active-high reset
- run  in  1  level; 1 = execute continuously
- step  in  1  single-cycle pulse; executes exactly one instruction when idle and run=0
- im_addr  out  PC_W  instruction memory address (= pc)
- im_data  in  IW  instruction word; combinational read of im_addr
- instr  out  IW  instruction register; drives decoder input
- exec_en  out  1  execute strobe; AND-ed with decoder RF_we and D_wd downstream
- pc  out  PC_W  current program counter
- halted  out  1  sticky; halt opcode executed
- illegal  out  1  sticky; unsupported opcode encountered
- retired  out  CNT_W  count of executed instructions

## Operation
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- IDLE:
  - to FETCH if run=1, or if step=1.
  - otherwise hold.
  - exec_en=0.
- FETCH:
  - im_addr=pc.
  - instr <= im_data at end of cycle.
  - to DECODE.
- DECODE:
  - instr stable; decoder outputs settle.
  - exec_en=0.
  - to EXEC.
- EXEC, by instr[11:9]:
  - Legal opcodes 000 load, 001 store, 101 add, 110 sub:
    - exec_en=1 for this one cycle.
    - pc <= pc+1; wraps 15->0 without a flag.
    - retired increments.
  - Opcode 111 (halt):
    - exec_en=0, pc unchanged, halted <= 1.
    - to HALT.
  - Opcodes 010, 011, 100:
    - exec_en=0.
    - illegal <= 1.
    - pc <= pc+1; treated as NOP; retired not incremented.
  - Exit from EXEC (non-halt): to FETCH if run=1, else to IDLE.
- HALT:
  - Absorbing; run and step ignored.
  - Only reset leaves it.
- step is ignored outside IDLE.
- step and run both high in IDLE: run mode, identical to run alone.
- run falling mid-instruction: the current instruction completes, then IDLE.
- illegal and halted are sticky until reset.

## Timing
- Reset values: state IDLE, pc=0, im_addr=0, instr=0, exec_en=0, halted=0, illegal=0, retired=0.
- Reset asserted mid-instruction: all outputs return to reset values immediately. No write strobe is produced for the aborted instruction.
- Latency:
  - run sampled high in IDLE at edge N.
  - FETCH in cycle N+1, DECODE N+2, EXEC N+3.
  - Free-run throughput: one instruction per 3 cycles.
  - Back-to-back: EXEC is followed directly by FETCH; no idle bubble.
- exec_en is registered-state decoded (EXEC state), glitch-free. It is never high for two consecutive cycles.
- pc and retired update at the edge ending EXEC. pc in EXEC still equals the address of the executing instruction.
- im_data must be valid within the FETCH cycle (asynchronous-read ROM).

## Configuration
- INSTR_SEQ_COUNT_EN defined:
  - retired counts legal executed instructions.
  - Saturates at 2^CNT_W-1; no wrap.
- INSTR_SEQ_COUNT_EN undefined:
  - No counter is built.
  - retired is tied to 0; the port stays present.

## Test plan
- Reset, then run=1 with ROM[0]=12'h012 (load), ROM[1]=12'h245 (store), ROM[2]=12'hE00 (halt):
  - exec_en pulses at cycles 3 and 6.
  - halted=1 after cycle 9.
  - pc=2; retired=2.
- run=0, a single step pulse: exactly one exec_en pulse, pc 0->1, back in IDLE. A second step pulse during DECODE has no effect.
- ROM[0]=12'h400 (opcode 010):
  - illegal=1, exec_en stays 0.
  - pc advances to 1; retired stays 0.
- 16 adds in free run: pc wraps 15->0 and execution continues from address 0.
- reset pulsed during DECODE: exec_en never asserts, pc=0, state IDLE, instr=0.
- With the macro defined, 300 legal instructions: retired saturates at 255.
